// File: rtl/axis_usb_tx_arbiter_pkg.sv
// Shared definitions for the USB transmit arbiter: frame magics, FSM states
// and header/trailer field layout (also used by the host-side parser model).
package axis_usb_tx_arbiter_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [7:0] TRL_MAGIC = 8'h5A;

  // Byte positions inside the 32-bit header and trailer words
  localparam int MAGIC_LSB = 24;
  localparam int CH_LSB    = 16;
  localparam int SEQ_LSB   = 8;
  localparam int NREAL_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    PAD,
    TRAILER
  } state_e;

  function automatic logic [31:0] make_header(input logic [7:0] ch, input logic [7:0] seq);
    logic [31:0] w;
    w = '0;
    w[MAGIC_LSB +: 8] = HDR_MAGIC;
    w[CH_LSB +: 8]    = ch;
    w[SEQ_LSB +: 8]   = seq;
    return w;
  endfunction

  function automatic logic [31:0] make_trailer(input logic [7:0] ch, input logic [15:0] nreal);
    logic [31:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]  = TRL_MAGIC;
    w[CH_LSB +: 8]     = ch;
    w[NREAL_LSB +: 16] = nreal;
    return w;
  endfunction

endpackage

// File: rtl/axis_usb_tx_arbiter_rr_select.sv
// Combinational round-robin priority encoder: first set request at or above
// i_ptr, wrapping modulo N.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_grant,
  output logic         o_any
);

  logic [W-1:0] w_idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins last.
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = W'((int'(i_ptr) + i) % N);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_usb_tx_arbiter.sv
// Round-robin framer sharing one 32-bit AXI4-Stream USB transmit path among
// CHANNELS sources: header, BURST payload slots (padded on stall), trailer.
module axis_usb_tx_arbiter
  import axis_usb_tx_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int BURST    = 256,
  parameter int TIMEOUT  = 64
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [32*CHANNELS-1:0]   s_axis_tdata,
  input  logic [CHANNELS-1:0]      s_axis_tvalid,
  output logic [CHANNELS-1:0]      s_axis_tready,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam int              GW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int              IW         = $clog2(TIMEOUT) + 1;
  localparam logic [15:0]     LAST_SLOT  = 16'(BURST - 1);
  localparam logic [IW-1:0]   IDLE_LIMIT = IW'(TIMEOUT - 1);
  localparam logic [GW-1:0]   LAST_CH    = GW'(CHANNELS - 1);

  state_e        r_state, w_next;
  logic [GW-1:0] r_g, r_ptr, w_grant;
  logic [15:0]   r_cnt, r_nreal;
  logic [IW-1:0] r_idle;
  logic [7:0]    r_seq [CHANNELS];
  logic          w_any, w_src_valid, w_hs, w_last_slot, w_timeout;

  rr_select #(.N(CHANNELS), .W(GW)) u_rr_select (
    .i_req   (s_axis_tvalid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_src_valid = s_axis_tvalid[r_g];
  assign w_hs        = m_axis_tvalid & m_axis_tready;
  assign w_last_slot = (r_cnt == LAST_SLOT);
  assign w_timeout   = !w_src_valid && (r_idle == IDLE_LIMIT);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    case (r_state)
      IDLE: if (w_any) w_next = HEADER;
      HEADER: begin
        m_axis_tdata  = make_header(8'(r_g), r_seq[r_g]);
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) w_next = DATA;
      end
      DATA: begin
        m_axis_tdata       = s_axis_tdata[32*r_g +: 32];
        m_axis_tvalid      = w_src_valid;
        s_axis_tready[r_g] = m_axis_tready;
        // A transfer always beats a simultaneous timeout.
        if (w_src_valid && m_axis_tready) begin
          if (w_last_slot) w_next = TRAILER;
        end else if (w_timeout) begin
          w_next = PAD;
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready && w_last_slot) w_next = TRAILER;
      end
      TRAILER: begin
        m_axis_tdata  = make_trailer(8'(r_g), r_nreal);
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_g     <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_nreal <= '0;
      r_idle  <= '0;
      // NOTE: this small array is reset explicitly because sequence numbers
      // must restart at zero; large RAM-style arrays would not be.
      for (int i = 0; i < CHANNELS; i++) r_seq[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_g     <= w_grant;
          r_ptr   <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
          r_cnt   <= '0;
          r_nreal <= '0;
          r_idle  <= '0;
        end
        DATA: begin
          if (w_hs) begin
            r_cnt   <= r_cnt + 16'd1;
            r_nreal <= r_nreal + 16'd1;
            r_idle  <= '0;
          end else if (!w_src_valid) begin
            r_idle  <= r_idle + 1'b1;
          end
        end
        PAD:     if (w_hs) r_cnt <= r_cnt + 16'd1;
        TRAILER: if (w_hs) r_seq[r_g] <= r_seq[r_g] + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_usb_tx_arbiter.sv
// Scoreboard bench for axis_usb_tx_arbiter: a frame-level model queues every
// expected output word; an independent monitor compares each presented word.
module tb_axis_usb_tx_arbiter;

  localparam int C           = 4;
  localparam int BURST       = 4;
  localparam int TIMEOUT     = 8;
  localparam int FRAME_LIMIT = 2000;

  logic              aclk = 1'b0;
  logic              areset;
  logic [32*C-1:0]   s_axis_tdata;
  logic [C-1:0]      s_axis_tvalid;
  logic [C-1:0]      s_axis_tready;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  always #5 aclk = ~aclk;

  axis_usb_tx_arbiter #(.CHANNELS(C), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  typedef enum {K_HDR, K_DAT, K_PAD, K_TRL} kind_e;
  typedef struct {
    logic [31:0] data;
    kind_e       kind;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;
  int   m_seq [C];
  bit   rdy_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t, required completion", name, $time);
  endtask

  // Round-robin choice: first requester at or after the model pointer.
  function automatic int pick(input logic [C-1:0] req);
    for (int i = 0; i < C; i++) begin
      int c = (m_ptr + i) % C;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  task automatic push_frame(input int g, input int k, input logic [31:0] words[$]);
    exp_t e;
    e.data = {8'hA5, 8'(g), 8'(m_seq[g]), 8'h00}; e.kind = K_HDR; exp_q.push_back(e);
    for (int i = 0; i < BURST; i++) begin
      if (i < k) begin e.data = words[i]; e.kind = K_DAT; end
      else       begin e.data = 32'h0;    e.kind = K_PAD; end
      exp_q.push_back(e);
    end
    e.data = {8'h5A, 8'(g), 16'(k)}; e.kind = K_TRL; exp_q.push_back(e);
    m_seq[g] = (m_seq[g] + 1) % 256;
  endtask

  // One frame: request vector, k real words, then the source stalls for good.
  // junk re-raises the source during padding; abort_at returns early.
  task automatic run_frame(input logic [C-1:0] req, input int k, input bit inc_data,
                           input bit junk, input int abort_at);
    int g, sent, hs, low, gap, cyc;
    bit xfer;
    logic [C-1:0] others;
    logic [31:0] words[$];
    g = pick(req);
    m_ptr = (g + 1) % C;
    for (int i = 0; i < k; i++) words.push_back(inc_data ? 32'(32'h10 + i) : $urandom);
    push_frame(g, k, words);
    others = '1;
    others[g] = 1'b0;

    @(negedge aclk);
    for (int c = 0; c < C; c++) s_axis_tdata[32*c +: 32] = $urandom;
    if (k > 0) s_axis_tdata[32*g +: 32] = words[0];
    s_axis_tvalid = req;
    #4;
    check("idle_before_grant", 32'(m_axis_tvalid), 32'd0);

    sent = 0; hs = 0; low = 0; gap = 0; cyc = 0; xfer = 1'b0;
    while (hs < BURST + 2 && cyc < FRAME_LIMIT) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        check("hdr_latency", 32'(m_axis_tvalid), 32'd1);
        s_axis_tvalid    = '0;
        s_axis_tvalid[g] = (k > 0);
      end else if (sent < k) begin
        if (xfer || !s_axis_tvalid[g]) begin
          s_axis_tdata[32*g +: 32] = words[sent];
          s_axis_tvalid[g] = !(gap < TIMEOUT - 2 && $urandom_range(2) == 0);
        end
      end else if (junk && hs >= 1 + k && low >= TIMEOUT + 1 && hs < BURST + 1) begin
        s_axis_tdata[32*g +: 32] = 32'hBAD0_0000 | 32'($urandom_range(255));
        s_axis_tvalid[g] = 1'b1;
      end else begin
        s_axis_tvalid[g] = 1'b0;
      end
      #4;
      check("ready_only_granted", 32'(s_axis_tready & others), 32'd0);
      if (k < BURST && hs >= 1 + k && low >= TIMEOUT + 1)
        check("pad_no_ready", 32'(s_axis_tready[g]), 32'd0);
      xfer = s_axis_tvalid[g] && s_axis_tready[g];
      if (xfer) begin sent++; gap = 0; end
      else if (!s_axis_tvalid[g]) gap++;
      if (hs >= 1 + k && !s_axis_tvalid[g]) low++;
      if (m_axis_tvalid && m_axis_tready) hs++;
      if (abort_at > 0 && sent == abort_at) break;
    end
    if (cyc >= FRAME_LIMIT) flag_fail("frame_timeout");
  endtask

  // Monitor: every presented word must match the queue head; pop on handshake.
  initial begin : monitor
    bit prev_trl;
    exp_t front;
    prev_trl = 1'b0;
    forever begin
      @(negedge aclk);
      #4;
      if (areset) begin
        prev_trl = 1'b0;
        continue;
      end
      if (prev_trl) begin
        check("bubble_after_trailer", 32'(m_axis_tvalid), 32'd0);
        prev_trl = 1'b0;
      end
      check("ready_onehot0", 32'($countones(s_axis_tready) <= 1), 32'd1);
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_axis_tdata, 32'hXXXX_XXXX);
        end else begin
          front = exp_q[0];
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            check(front.kind == K_HDR ? "header" : front.kind == K_TRL ? "trailer" :
                  front.kind == K_PAD ? "pad" : "data", m_axis_tdata, front.data);
            prev_trl = (front.kind == K_TRL);
          end else begin
            check("held_word", m_axis_tdata, front.data);
          end
        end
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      m_axis_tready = rdy_random ? ($urandom_range(9) < 7) : 1'b1;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    int w;
    for (int i = 0; i < C; i++) m_seq[i] = 0;
    areset        = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    #1;
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // Single source ch2 with known payload, twice (sequence advances).
    run_frame(4'b0100, BURST, 1'b1, 1'b0, 0);
    run_frame(4'b0100, BURST, 1'b1, 1'b0, 0);
    // All sources busy: round-robin rotation with one bubble per frame.
    repeat (5) run_frame(4'b1111, BURST, 1'b0, 1'b0, 0);
    // ch1 stalls after two words; words offered during padding are refused.
    run_frame(4'b0010, 2, 1'b0, 1'b1, 0);

    rdy_random = 1'b1;
    repeat (40) begin
      run_frame(C'($urandom_range(1, (1 << C) - 1)), $urandom_range(0, BURST),
                1'b0, 1'($urandom_range(1)), 0);
      repeat ($urandom_range(2)) @(negedge aclk);
    end

    // Sequence wrap on ch0; ch3 keeps its own count.
    repeat (256) run_frame(4'b0001, BURST, 1'b0, 1'b0, 0);
    run_frame(4'b1000, BURST, 1'b0, 1'b0, 0);

    // Reset in the middle of a frame after two transfers.
    run_frame(4'b0010, BURST, 1'b0, 1'b0, 2);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("abort_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("abort_s_tready", 32'(s_axis_tready), 32'd0);
    check("abort_m_tdata", m_axis_tdata, 32'd0);
    s_axis_tvalid = '0;
    exp_q.delete();
    m_ptr = 0;
    for (int i = 0; i < C; i++) m_seq[i] = 0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    run_frame(4'b1111, 2, 1'b0, 1'b0, 0);

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge aclk);
      w++;
    end
    if (exp_q.size() != 0) flag_fail("drain");
    @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_usb_tx_arbiter.md
# axis_usb_tx_arbiter

- Round-robin scheduler that shares the USB transmit stream among several 32-bit AXI4-Stream sources.
- Grants one source at a time and wraps its data in a fixed-length frame: header, exactly BURST payload slots, trailer.
- Pads the frame if the granted source stalls too long.
- Sits in the aclk domain directly in front of the USB bridge's s_axis input; the host demultiplexes frames by channel field.

## Interface
- CHANNELS, 4: number of sources, 1..16.
- BURST, 256: payload slots per frame, 1..65535.
- TIMEOUT, 64: consecutive idle DATA cycles before padding starts, ≥1.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  32*CHANNELS  source data; channel i at bits [32*i+31:32*i].
- s_axis_tvalid  in  CHANNELS  per-source valid.
- s_axis_tready  out  CHANNELS  per-source ready; at most one bit high at any time.
- m_axis_tdata  out  32  framed stream to USB bridge.
- m_axis_tvalid  out  1  framed stream valid.
- m_axis_tready  in  1  USB bridge ready.

## Operation
- State machine states: IDLE, HEADER, DATA, PAD, TRAILER.
- Registers:
  - Grant index g.
  - Priority pointer ptr.
  - Slot counter cnt (16 bit).
  - Real-word counter nreal (16 bit).
  - Idle counter.
  - Per-channel 8-bit sequence seq[i].

State behaviour:
- IDLE:
  - Scan s_axis_tvalid from ptr upward, modulo CHANNELS.
  - On the first set bit, load g, set ptr ← (g+1) mod CHANNELS, clear cnt/nreal/idle, go to HEADER.
  - If no bit is set, stay in IDLE.
- HEADER:
  - m_axis_tdata = {8'hA5, 8'(g), seq[g], 8'h00}, m_axis_tvalid = 1.
  - On handshake, go to DATA.
- DATA:
  - Pass-through: m_axis_tdata = s_axis_tdata[g], m_axis_tvalid = s_axis_tvalid[g], s_axis_tready[g] = m_axis_tready.
  - On each transfer: cnt++, nreal++, idle ← 0.
  - A transfer with cnt == BURST-1 goes to TRAILER.
  - idle increments on every cycle with s_axis_tvalid[g] = 0, regardless of m_axis_tready.
  - When idle == TIMEOUT-1 and s_axis_tvalid[g] = 0, go to PAD.
- PAD:
  - m_axis_tdata = 32'h0, m_axis_tvalid = 1, all s_axis_tready = 0.
  - On each transfer cnt++.
  - The transfer with cnt == BURST-1 goes to TRAILER.
- TRAILER:
  - m_axis_tdata = {8'h5A, 8'(g), nreal}, m_axis_tvalid = 1.
  - On handshake: seq[g]++ (wraps 255→0), go to IDLE.

Rules:
- Outside DATA, all s_axis_tready = 0.
- Once a frame starts, it always completes with exactly BURST+2 words; padding is never interrupted by the source becoming valid again.
- Sources deasserting tvalid in IDLE lose nothing; arbitration is re-evaluated every IDLE cycle.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, g = 0, all seq = 0, counters = 0.
  - m_axis_tvalid = 0, s_axis_tready = 0, m_axis_tdata = 0.
- Latency:
  - Valid source in IDLE → header on m_axis next cycle.
  - DATA path is combinational, zero latency, no bubbles.
  - One IDLE bubble cycle between consecutive frames.
- AXI-Stream rules:
  - Once m_axis_tvalid rises in HEADER/PAD/TRAILER, it and m_axis_tdata stay stable until handshake.
  - In DATA, stability is inherited from the source.
- Simultaneous events in DATA:
  - A transfer and idle == TIMEOUT-1 in the same cycle: the transfer wins and idle clears.
- BURST = 1: the single DATA transfer goes directly to TRAILER.
- areset mid-frame aborts it immediately: outputs drop the same cycle and the frame is not completed.

## Structure
- Shared package holds:
  - HDR_MAGIC = 8'hA5, TRL_MAGIC = 8'h5A.
  - State enum.
  - Header/trailer field positions, shared with the host-side parser test model.
- Natural sub-module: rr_select, combinational round-robin priority encoder (request vector, ptr → grant index, any).
- FSM, counters and the output mux stay in the top module.

## Test plan
1. CHANNELS=4, BURST=4: only ch2 streams 0x10..0x13 → m_axis: A5020000, 10, 11, 12, 13, 5A020004; next frame from ch2 has seq=01.
2. All four channels continuously valid → frames in order ch0, ch1, ch2, ch3, ch0; exactly one s_axis_tready bit high in DATA; one IDLE cycle between frames.
3. ch1 sends 2 words then stalls, TIMEOUT=8 → after 8 idle cycles: 00000000, 00000000, then trailer 5A010002; ch1 words arriving during PAD are not accepted.
4. m_axis_tready toggled randomly during all states → header/pad/trailer words held stable; no data lost or duplicated; each frame is BURST+2 words.
5. 256 frames on ch0 → seq wraps FF→00; ch3 seq unaffected.
6. areset asserted in DATA after 2 transfers → m_axis_tvalid = 0 immediately; after release, next frame header shows seq 00 and ptr restarts from ch0.
